axil_reg_if: RTL and testbench

AXIL_REG_IF -- requirements
Module: axil_reg_if

---
 rtl/axil_reg_if_if.sv | 40 ++++
 rtl/axil_reg_if.sv | 241 ++++++++++++++++++++++++
 tb/tb_axil_reg_if.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_reg_if_if.sv
// AXI-Lite bus bundle between an AXI-Lite master (or register slice) and the
// register-interface bridge. The master modport drives address/data/valid and
// the response-ready strobes; the slave modport returns readies and responses.
interface axil_reg_if_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_reg_if.sv
// AXI-Lite slave to simple register-bus bridge. Independent write and read
// paths, each with one-entry holders, a held enable towards the register side,
// and an idle-cycle timeout that turns an unanswered access into SLVERR.
module axil_reg_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axil_reg_if_if.slave          s_axil,
    output logic [ADDR_WIDTH-1:0] reg_wr_addr,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    output logic [STRB_WIDTH-1:0] reg_wr_strb,
    output logic                  reg_wr_en,
    input  logic                  reg_wr_wait,
    input  logic                  reg_wr_ack,
    output logic [ADDR_WIDTH-1:0] reg_rd_addr,
    output logic                  reg_rd_en,
    input  logic [DATA_WIDTH-1:0] reg_rd_data,
    input  logic                  reg_rd_wait,
    input  logic                  reg_rd_ack
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [7:0] TMO_LOAD    = 8'(TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

    // Holder state
    logic                  aw_full_q, aw_full_d;
    logic                  w_full_q,  w_full_d;
    logic                  ar_full_q, ar_full_d;
    logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q,   wstrb_d;
    logic [ADDR_WIDTH-1:0] araddr_q,  araddr_d;
    // Readies are flops so they read 0 throughout reset
    logic                  awready_q, wready_q, arready_q;

    // Write path FSM state and registered outputs
    state_t                wr_state_q;
    logic                  wr_en_q;
    logic [7:0]            wr_cnt_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;

    // Read path FSM state and registered outputs
    state_t                rd_state_q;
    logic                  rd_en_q;
    logic [7:0]            rd_cnt_q;
    logic                  rvalid_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  wr_done;
    logic                  rd_done;

    // Protection bits carry no meaning for this register bus
    logic unused_prot;
    assign unused_prot = ^{s_axil.awprot, s_axil.arprot};

    // Next holder contents: fill when empty, empty on the B/R handshake
    always_comb begin
        wr_done   = (wr_state_q == ST_RESP) && s_axil.bready;
        rd_done   = (rd_state_q == ST_RESP) && s_axil.rready;
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        ar_full_d = ar_full_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        araddr_d  = araddr_q;
        if (wr_done) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end else begin
            if (s_axil.awvalid && awready_q) begin
                aw_full_d = 1'b1;
                awaddr_d  = s_axil.awaddr;
            end
            if (s_axil.wvalid && wready_q) begin
                w_full_d = 1'b1;
                wdata_d  = s_axil.wdata;
                wstrb_d  = s_axil.wstrb;
            end
        end
        if (rd_done) begin
            ar_full_d = 1'b0;
        end else if (s_axil.arvalid && arready_q) begin
            ar_full_d = 1'b1;
            araddr_d  = s_axil.araddr;
        end
    end

    // Holder registers and their readies
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            ar_full_q <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            araddr_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
        end else begin
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            ar_full_q <= ar_full_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            araddr_q  <= araddr_d;
            awready_q <= !aw_full_d;
            wready_q  <= !w_full_d;
            arready_q <= !ar_full_d;
        end
    end

    // Write FSM: start once both holders will be full, finish on ack or timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= ST_IDLE;
            wr_en_q    <= 1'b0;
            wr_cnt_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            case (wr_state_q)
                ST_IDLE: begin
                    if (aw_full_d && w_full_d) begin
                        wr_state_q <= ST_ACCESS;
                        wr_en_q    <= 1'b1;
                        wr_cnt_q   <= TMO_LOAD;
                    end
                end
                ST_ACCESS: begin
                    if (reg_wr_ack) begin
                        wr_state_q <= ST_RESP;
                        wr_en_q    <= 1'b0;
                        wr_cnt_q   <= '0;
                        bvalid_q   <= 1'b1;
                        bresp_q    <= RESP_OKAY;
                    end else if (!reg_wr_wait) begin
                        // The decrement that would reach zero ends the access
                        if (wr_cnt_q == 8'd1) begin
                            wr_state_q <= ST_RESP;
                            wr_en_q    <= 1'b0;
                            bvalid_q   <= 1'b1;
                            bresp_q    <= RESP_SLVERR;
                        end
                        wr_cnt_q <= wr_cnt_q - 8'd1;
                    end
                end
                ST_RESP: begin
                    if (s_axil.bready) begin
                        wr_state_q <= ST_IDLE;
                        bvalid_q   <= 1'b0;
                    end
                end
                default: begin
                    wr_state_q <= ST_IDLE;
                    wr_en_q    <= 1'b0;
                    bvalid_q   <= 1'b0;
                end
            endcase
        end
    end

    // Read FSM: same shape as the write side, plus capture of read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= ST_IDLE;
            rd_en_q    <= 1'b0;
            rd_cnt_q   <= '0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            case (rd_state_q)
                ST_IDLE: begin
                    if (ar_full_d) begin
                        rd_state_q <= ST_ACCESS;
                        rd_en_q    <= 1'b1;
                        rd_cnt_q   <= TMO_LOAD;
                    end
                end
                ST_ACCESS: begin
                    if (reg_rd_ack) begin
                        rd_state_q <= ST_RESP;
                        rd_en_q    <= 1'b0;
                        rd_cnt_q   <= '0;
                        rvalid_q   <= 1'b1;
                        rresp_q    <= RESP_OKAY;
                        rdata_q    <= reg_rd_data;
                    end else if (!reg_rd_wait) begin
                        if (rd_cnt_q == 8'd1) begin
                            rd_state_q <= ST_RESP;
                            rd_en_q    <= 1'b0;
                            rvalid_q   <= 1'b1;
                            rresp_q    <= RESP_SLVERR;
                            rdata_q    <= '0;
                        end
                        rd_cnt_q <= rd_cnt_q - 8'd1;
                    end
                end
                ST_RESP: begin
                    if (s_axil.rready) begin
                        rd_state_q <= ST_IDLE;
                        rvalid_q   <= 1'b0;
                    end
                end
                default: begin
                    rd_state_q <= ST_IDLE;
                    rd_en_q    <= 1'b0;
                    rvalid_q   <= 1'b0;
                end
            endcase
        end
    end

    assign s_axil.awready = awready_q;
    assign s_axil.wready  = wready_q;
    assign s_axil.arready = arready_q;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rresp   = rresp_q;
    assign s_axil.rdata   = rdata_q;

    assign reg_wr_addr = awaddr_q;
    assign reg_wr_data = wdata_q;
    assign reg_wr_strb = wstrb_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_rd_addr = araddr_q;
    assign reg_rd_en   = rd_en_q;
endmodule

// File: tb/tb_axil_reg_if.sv
// Bench for axil_reg_if: directed scenarios plus randomized write/read traffic,
// with a register-side responder and an arithmetic model of the expected
// enable length, response code and read data.
`timescale 1ns/1ps
module tb_axil_reg_if;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = 4;
    localparam int TO = 4;
    localparam int NEVER = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axil_reg_if_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) bus ();

    logic [AW-1:0] reg_wr_addr, reg_rd_addr;
    logic [DW-1:0] reg_wr_data, reg_rd_data;
    logic [SW-1:0] reg_wr_strb;
    logic          reg_wr_en, reg_wr_wait, reg_wr_ack;
    logic          reg_rd_en, reg_rd_wait, reg_rd_ack;

    axil_reg_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_axil      (bus),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .reg_wr_strb (reg_wr_strb),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_wait (reg_wr_wait),
        .reg_wr_ack  (reg_wr_ack),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_data (reg_rd_data),
        .reg_rd_wait (reg_rd_wait),
        .reg_rd_ack  (reg_rd_ack)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Register-side responder configuration
    int          wr_ack_at = NEVER, wr_wait_n = 0, wr_idx = 0;
    int          rd_ack_at = NEVER, rd_wait_n = 0, rd_idx = 0;
    logic [31:0] rd_value = '0;
    bit          stray_en = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected outcome: wait cycles hold the timer, then TO idle cycles remain
    function automatic void predict(input int ack_at, input int wait_n,
                                    output int len, output logic [1:0] resp);
        int tmo_idx;
        tmo_idx = wait_n + TO - 1;
        if (ack_at <= tmo_idx) begin
            len  = ack_at + 1;
            resp = 2'b00;
        end else begin
            len  = tmo_idx + 1;
            resp = 2'b10;
        end
    endfunction

    // Write responder: ack/wait keyed on the index of the enable cycle
    initial begin
        reg_wr_ack  = 1'b0;
        reg_wr_wait = 1'b0;
        forever begin
            @(negedge clk);
            if (reg_wr_en) begin
                reg_wr_ack  = (wr_idx == wr_ack_at);
                reg_wr_wait = (wr_idx < wr_wait_n);
                wr_idx++;
            end else begin
                wr_idx      = 0;
                reg_wr_ack  = stray_en && ($urandom_range(0, 1) == 1);
                reg_wr_wait = ($urandom_range(0, 1) == 1);
            end
        end
    end

    // Read responder: only the ack cycle carries the intended data
    initial begin
        reg_rd_ack  = 1'b0;
        reg_rd_wait = 1'b0;
        reg_rd_data = '0;
        forever begin
            @(negedge clk);
            if (reg_rd_en) begin
                reg_rd_ack  = (rd_idx == rd_ack_at);
                reg_rd_wait = (rd_idx < rd_wait_n);
                reg_rd_data = (rd_idx == rd_ack_at) ? rd_value : $urandom;
                rd_idx++;
            end else begin
                rd_idx      = 0;
                reg_rd_ack  = stray_en && ($urandom_range(0, 1) == 1);
                reg_rd_wait = ($urandom_range(0, 1) == 1);
                reg_rd_data = $urandom;
            end
        end
    end

    // w_lead > 0: W leads AW by w_lead cycles; w_lead < 0: AW leads
    task automatic axi_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int w_lead, input int ack_at, input int wait_n, input int bdelay);
        int aw_start, w_start, c, len, exp_len;
        logic [1:0] exp_resp;
        bit aw_done, w_done, aw_hs, w_hs;
        aw_start = (w_lead > 0) ? w_lead : 0;
        w_start  = (w_lead < 0) ? -w_lead : 0;
        predict(ack_at, wait_n, exp_len, exp_resp);
        wr_ack_at   = ack_at;
        wr_wait_n   = wait_n;
        bus.awaddr  = addr;
        bus.awprot  = 3'($urandom);
        bus.wdata   = data;
        bus.wstrb   = strb;
        c = 0; aw_done = 1'b0; w_done = 1'b0;
        while (!(aw_done && w_done) && c < 40) begin
            bus.awvalid = !aw_done && (c >= aw_start);
            bus.wvalid  = !w_done && (c >= w_start);
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            @(posedge clk); #1;
            if (aw_hs) aw_done = 1'b1;
            if (w_hs) w_done = 1'b1;
            if (w_hs && !aw_done) check_val("wready_after_w", 32'(bus.wready), 0);
            if (!(aw_done && w_done)) check_val("no_wr_en_early", 32'(reg_wr_en), 0);
            c++;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check_val("wr_hs_done", 32'(aw_done && w_done), 1);
        check_val("wr_en_start", 32'(reg_wr_en), 1);
        len = 0;
        while (reg_wr_en && len < 300) begin
            check_val("wr_addr", 32'(reg_wr_addr), 32'(addr));
            check_val("wr_data", reg_wr_data, data);
            check_val("wr_strb", 32'(reg_wr_strb), 32'(strb));
            @(posedge clk); #1;
            len++;
        end
        check_val("wr_en_len", len, exp_len);
        check_val("bvalid", 32'(bus.bvalid), 1);
        check_val("bresp", 32'(bus.bresp), 32'(exp_resp));
        for (int i = 0; i < bdelay; i++) begin
            @(posedge clk); #1;
            check_val("bvalid_hold", 32'(bus.bvalid), 1);
            check_val("bresp_hold", 32'(bus.bresp), 32'(exp_resp));
            check_val("wr_en_in_resp", 32'(reg_wr_en), 0);
        end
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        check_val("bvalid_clear", 32'(bus.bvalid), 0);
        check_val("awready_after_b", 32'(bus.awready), 1);
        check_val("wready_after_b", 32'(bus.wready), 1);
        $display("WR addr=0x%04h data=0x%08h strb=0x%h lead=%0d ack_at=%0d wait=%0d en_len=%0d resp=%0d",
                 addr, data, strb, w_lead, ack_at, wait_n, len, exp_resp);
    endtask

    task automatic axi_read(input logic [15:0] addr, input logic [31:0] data,
                            input int ack_at, input int wait_n, input int rdelay);
        int c, len, exp_len;
        logic [1:0] exp_resp;
        logic [31:0] exp_data;
        bit ar_done, ar_hs;
        predict(ack_at, wait_n, exp_len, exp_resp);
        exp_data   = (exp_resp == 2'b00) ? data : 32'h0;
        rd_ack_at  = ack_at;
        rd_wait_n  = wait_n;
        rd_value   = data;
        bus.araddr = addr;
        bus.arprot = 3'($urandom);
        c = 0; ar_done = 1'b0;
        while (!ar_done && c < 40) begin
            bus.arvalid = 1'b1;
            ar_hs = bus.arready;
            @(posedge clk); #1;
            if (ar_hs) ar_done = 1'b1;
            else check_val("no_rd_en_early", 32'(reg_rd_en), 0);
            c++;
        end
        bus.arvalid = 1'b0;
        check_val("rd_hs_done", 32'(ar_done), 1);
        check_val("arready_full", 32'(bus.arready), 0);
        check_val("rd_en_start", 32'(reg_rd_en), 1);
        len = 0;
        while (reg_rd_en && len < 300) begin
            check_val("rd_addr", 32'(reg_rd_addr), 32'(addr));
            @(posedge clk); #1;
            len++;
        end
        check_val("rd_en_len", len, exp_len);
        check_val("rvalid", 32'(bus.rvalid), 1);
        check_val("rresp", 32'(bus.rresp), 32'(exp_resp));
        check_val("rdata", bus.rdata, exp_data);
        for (int i = 0; i < rdelay; i++) begin
            @(posedge clk); #1;
            check_val("rvalid_hold", 32'(bus.rvalid), 1);
            check_val("rresp_hold", 32'(bus.rresp), 32'(exp_resp));
            check_val("rdata_hold", bus.rdata, exp_data);
        end
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
        check_val("rvalid_clear", 32'(bus.rvalid), 0);
        check_val("arready_after_r", 32'(bus.arready), 1);
        $display("RD addr=0x%04h ack_at=%0d wait=%0d en_len=%0d resp=%0d rdata=0x%08h",
                 addr, ack_at, wait_n, len, exp_resp, exp_data);
    endtask

    task automatic check_all_idle(input string tag);
        check_val({tag, "_awready"}, 32'(bus.awready), 0);
        check_val({tag, "_wready"},  32'(bus.wready), 0);
        check_val({tag, "_arready"}, 32'(bus.arready), 0);
        check_val({tag, "_bvalid"},  32'(bus.bvalid), 0);
        check_val({tag, "_rvalid"},  32'(bus.rvalid), 0);
        check_val({tag, "_bresp"},   32'(bus.bresp), 0);
        check_val({tag, "_rresp"},   32'(bus.rresp), 0);
        check_val({tag, "_rdata"},   bus.rdata, 0);
        check_val({tag, "_wr_en"},   32'(reg_wr_en), 0);
        check_val({tag, "_rd_en"},   32'(reg_rd_en), 0);
    endtask

    task automatic reset_mid_access();
        wr_ack_at = NEVER; wr_wait_n = 0;
        rd_ack_at = NEVER; rd_wait_n = 0;
        bus.awaddr = 16'h0040; bus.wdata = 32'h0BAD0BAD; bus.wstrb = 4'hF;
        bus.araddr = 16'h0044;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        @(posedge clk); #1;
        check_val("rst_pre_wr_en", 32'(reg_wr_en), 1);
        check_val("rst_pre_rd_en", 32'(reg_rd_en), 1);
        rst_n = 1'b0;
        #1;
        check_all_idle("rst_now");
        repeat (2) @(posedge clk);
        #1;
        check_all_idle("rst_hold");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("rel_awready", 32'(bus.awready), 1);
        check_val("rel_wready",  32'(bus.wready), 1);
        check_val("rel_arready", 32'(bus.arready), 1);
        for (int i = 0; i < TO + 3; i++) begin
            check_val("rel_no_bvalid", 32'(bus.bvalid), 0);
            check_val("rel_no_rvalid", 32'(bus.rvalid), 0);
            check_val("rel_no_wr_en",  32'(reg_wr_en), 0);
            check_val("rel_no_rd_en",  32'(reg_rd_en), 0);
            @(posedge clk); #1;
        end
        $display("RST mid-access abandoned write 0x0040 and read 0x0044");
    endtask

    initial begin
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_idle("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("init_awready", 32'(bus.awready), 1);
        check_val("init_wready",  32'(bus.wready), 1);
        check_val("init_arready", 32'(bus.arready), 1);

        // Directed scenarios
        axi_write(16'h0010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
        axi_write(16'h0014, 32'hCAFEF00D, 4'h3, 3, 1, 0, 1);
        axi_write(16'h0018, 32'h01020304, 4'h8, -2, 2, 0, 0);
        axi_read(16'h0020, 32'h12345678, 2, 0, 3);
        axi_read(16'h0024, 32'hAAAA5555, NEVER, 0, 1);
        axi_write(16'h0028, 32'h55AA55AA, 4'hF, 0, NEVER, 0, 0);
        axi_write(16'h002C, 32'h11112222, 4'hF, 0, NEVER, 5, 2);
        axi_read(16'h0030, 32'h33334444, NEVER, 5, 0);
        axi_read(16'h0034, 32'h98765432, 3, 6, 0);
        fork
            axi_write(16'h0100, 32'hA5A5A5A5, 4'hF, 0, 1, 0, 0);
            axi_read(16'h0200, 32'h5A5A5A5A, 1, 0, 0);
        join

        // Randomized traffic, with stray acks outside access cycles
        stray_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int sel;
            sel = $urandom_range(0, 2);
            fork
                if (sel != 1)
                    axi_write(16'($urandom), $urandom, 4'($urandom), $urandom_range(0, 6) - 3,
                              $urandom_range(0, 10), $urandom_range(0, 4), $urandom_range(0, 3));
                if (sel != 0)
                    axi_read(16'($urandom), $urandom, $urandom_range(0, 10),
                             $urandom_range(0, 4), $urandom_range(0, 3));
            join
        end
        stray_en = 1'b0;

        reset_mid_access();
        axi_write(16'h0050, 32'hFEEDFACE, 4'hF, 0, 0, 0, 0);
        axi_read(16'h0054, 32'h0C0FFEE0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop if the flow above ever stalls
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "global timeout");
    end
endmodule
